// File: rtl/mux_rr_select.sv
// Round-robin select sequencer for a 2-bit 4x1 mux: registered select, one-hot grant, bounded dwell.
// Optional MUXSEL_LOCK_EN adds Lock_s, which freezes the dwell counter while a grant is held.
module mux_rr_select #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       Clk_s,
  input  logic       Rst_s,
  input  logic [3:0] Req_s,
  input  logic       Done_s,
`ifdef MUXSEL_LOCK_EN
  input  logic       Lock_s,
`endif
  output logic       S1_s,
  output logic       S0_s,
  output logic [3:0] Gnt_s,
  output logic       Valid_s
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]     gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic               lock_c;
  logic [IDX_W-1:0]   pick_c;
  logic               found_c;
  logic               release_c;

`ifdef MUXSEL_LOCK_EN
  assign lock_c = Lock_s;
`else
  assign lock_c = 1'b0;
`endif

  // First requester in ascending wrap order starting just after the last grant
  always_comb begin
    pick_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!found_c && Req_s[IDX_W'(last_q + IDX_W'(i))]) begin
        pick_c  = IDX_W'(last_q + IDX_W'(i));
        found_c = 1'b1;
      end
    end
  end

  assign release_c = ((cnt_q == '0) && !lock_c) || Done_s || !Req_s[sel_q];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (found_c) begin
          state_d = GRANT;
          sel_d   = pick_c;
          gnt_d   = NCH'(1) << pick_c;
          valid_d = 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = GAP;
          last_d  = sel_q;
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (!lock_c && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_s or negedge Rst_s) begin
    if (!Rst_s) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NCH - 1);
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign S1_s    = sel_q[1];
  assign S0_s    = sel_q[0];
  assign Gnt_s   = gnt_q;
  assign Valid_s = valid_q;

endmodule

// File: doc/mux_rr_select.md
# mux_rr_select

Round-robin select sequencer sitting directly upstream of the 2-bit 4x1 mux. It arbitrates among four requesting channels and drives the mux select pair S1_s/S0_s. It holds each grant for a bounded dwell time and flags when the selected mux output is valid for capture downstream. The registered select guarantees the mux data path sees a stable select for the whole grant window.

## Interface

- HOLD_CYCLES, default 4, maximum grant dwell in clock cycles; legal range 1..255.
- Clk_s  input  1  clock; all state updates on the rising edge.
- Rst_s  input  1  reset, asynchronous and active-low.
- Req_s  input  4  per-channel request; bit k requests mux input k (0=A, 1=B, 2=C, 3=D).
- Done_s  input  1  early release of the current grant, from the consumer.
- S1_s  output  1  mux select MSB, registered.
- S0_s  output  1  mux select LSB, registered.
- Gnt_s  output  4  one-hot grant, registered; all zero when no grant.
- Valid_s  output  1  high while the mux output for the granted channel is valid.

## Operation

- There are three states:
  - IDLE: no grant. Valid_s=0, Gnt_s=0, and S1_s/S0_s hold their last value.
  - GRANT: Valid_s=1, Gnt_s one-hot, and {S1_s,S0_s}=granted index.
  - GAP: one turnaround cycle. Valid_s=0, Gnt_s=0, and the select holds its value.
- Pointer Last_s (2 bits, internal) stores the index of the last granted channel.
- IDLE → GRANT when Req_s≠0:
  - The search starts at Last_s+1 (mod 4) and takes the first requesting index in ascending wrap order.
  - The dwell counter loads HOLD_CYCLES-1.
  - Select and Gnt_s update on the same edge.
- GRANT → GAP on the first cycle in which any of these holds:
  - the counter is 0;
  - Done_s=1;
  - Req_s[granted]=0.
- On GRANT → GAP, Last_s is set to the granted index. Otherwise the counter decrements once per GRANT cycle.
- GAP → IDLE unconditionally.
- Release conditions are evaluated on the current cycle's inputs. A Req_s drop ends the grant at the next edge, and Valid_s may stay high in the cycle of the drop.
- Requests from other channels never preempt a grant.
- If Req_s changes while in IDLE, only the value sampled at the edge matters.
- Counter width is 8 bits and never wraps below 0. With HOLD_CYCLES=1 the counter loads 0, giving exactly one GRANT cycle.

## Timing

- Reset values: S1_s=0, S0_s=0, Gnt_s=0000, Valid_s=0, state IDLE, Last_s=3 (so the first search order is 0,1,2,3), counter=0.
- Reset takes effect immediately on assertion, at any time including mid-grant; outputs go to their reset values without waiting for a clock.
- Request latency: Req_s sampled high at edge n gives Valid_s/Gnt_s/select at edge n (visible in cycle n+1).
- A grant lasts at most HOLD_CYCLES cycles of Valid_s=1.
- Minimum spacing between grants is 2 dead cycles (GAP, IDLE). With continuous requests, each channel's period is HOLD_CYCLES+2 cycles.
- If Done_s and counter=0 occur together, there is a single release; the behaviour is identical to either cause alone.
- Select changes only on the IDLE→GRANT edge. It is stable through GRANT and GAP.

## Configuration

- MUXSEL_LOCK_EN defined:
  - Adds input port Lock_s (1 bit).
  - While GRANT and Lock_s=1, the dwell counter is frozen and counter-expiry release is suppressed.
  - Done_s and a request drop still release the grant.
  - Lock_s is ignored outside GRANT.
- MUXSEL_LOCK_EN undefined: no Lock_s port; dwell is bounded strictly by HOLD_CYCLES.

## Test plan

- Reset, then Req_s=0001 held → after 1 edge: Gnt_s=0001, S=00, Valid_s=1 for 4 cycles, then 2 dead cycles, then re-grant to channel 0.
- Req_s=1111 held, HOLD_CYCLES=4 → grant order 0,1,2,3,0 with {S1_s,S0_s}=00,01,10,11,00; each Valid_s window is 4 cycles and the period is 6 cycles.
- Req_s=0100, Done_s pulsed in the 2nd GRANT cycle → Valid_s high exactly 2 cycles; Last_s=2; a following Req_s=0101 grants channel 0 next.
- Req_s=1000 granted, Req_s dropped to 0000 in GRANT cycle 1 → GAP at the next edge; S stays 11; Valid_s=0 from then on.
- Rst_s asserted low mid-grant (Gnt_s=0010) → S=00, Gnt_s=0000, Valid_s=0 immediately without a clock edge; after release with Req_s=0010 the grant returns in 1 cycle.
- MUXSEL_LOCK_EN, Req_s=0001, Lock_s=1 for 10 cycles → Valid_s stays high for 10+ cycles; after Lock_s falls with counter at 3, 4 more Valid_s cycles follow, then GAP.
